// File: rtl/md_issue_ctrl_if.sv
// Bundle between the E-stage pipeline register / D-stage decode and the
// multiply/divide issue controller. The pipeline side is the master.
interface md_issue_ctrl_if;
    logic        e_valid;
    logic [3:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_md_use;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall_d;
    logic        proto_err;

    modport master (
        output e_valid, e_op, e_rs, e_rt, d_md_use,
        input  md_op, md_a, md_b, stall_d, proto_err
    );

    modport slave (
        input  e_valid, e_op, e_rs, e_rt, d_md_use,
        output md_op, md_a, md_b, stall_d, proto_err
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue/interlock controller in front of the multiply/divide unit: holds the
// op and operands for the unit latency, then retires. MD_PROTO_CHECK_EN builds proto_err.
module md_issue_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    md_issue_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RETIRE = 2'd2
    } state_t;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [3:0] MULT_CNT = MULT_LAT[3:0];
    localparam logic [3:0] DIV_CNT  = DIV_LAT[3:0];

    // True for every opcode that occupies the unit.
    function automatic logic is_md_op(input logic [3:0] op);
        logic hit;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: hit = 1'b1;
            default:                                              hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Number of cycles the opcode is held at the unit inputs.
    function automatic logic [3:0] latency_of(input logic [3:0] op);
        logic [3:0] lat;
        case (op)
            OP_MULT, OP_MULTU: lat = MULT_CNT;
            OP_DIV, OP_DIVU:   lat = DIV_CNT;
            OP_MTHI, OP_MTLO:  lat = 4'd1;
            default:           lat = 4'd0;
        endcase
        return lat;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nxt_s;
    logic [3:0]  md_op_r;
    logic [3:0]  md_op_nxt_s;
    logic [31:0] md_a_r;
    logic [31:0] md_b_r;
    logic        issue_now_s;
    logic        proto_err_r;

    // Next-state, countdown and issue decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        issue_now_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.e_valid && is_md_op(bus.e_op)) begin
                    issue_now_s = 1'b1;
                    state_nxt_s = RUN;
                    cnt_nxt_s   = latency_of(bus.e_op);
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            RUN: begin
                // A count of 0 cannot occur legitimately; treat it as done.
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = RETIRE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            RETIRE: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Opcode to the unit: new op on issue, held through RUN, zero otherwise.
    always_comb begin
        md_op_nxt_s = OP_NONE;
        if (issue_now_s) begin
            md_op_nxt_s = bus.e_op;
        end else if (state_nxt_s == RUN) begin
            md_op_nxt_s = md_op_r;
        end else begin
            md_op_nxt_s = OP_NONE;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Hold registers; operands only load on an accepted issue so a
    // rejected op never disturbs the running operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_op_r <= OP_NONE;
            md_a_r  <= 32'd0;
            md_b_r  <= 32'd0;
        end else begin
            md_op_r <= md_op_nxt_s;
            if (issue_now_s) begin
                md_a_r <= bus.e_rs;
                md_b_r <= bus.e_rt;
            end else begin
                md_a_r <= md_a_r;
                md_b_r <= md_b_r;
            end
        end
    end

`ifdef MD_PROTO_CHECK_EN
    logic violation_s;

    // Any non-empty op arriving while the unit is occupied.
    always_comb begin
        violation_s = 1'b0;
        if (bus.e_valid && (bus.e_op != OP_NONE) && (state_r != IDLE)) begin
            violation_s = 1'b1;
        end else begin
            violation_s = 1'b0;
        end
    end

    // Sticky violation flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_r <= 1'b0;
        end else begin
            proto_err_r <= proto_err_r | violation_s;
        end
    end
`else
    assign proto_err_r = 1'b0;
`endif

    assign bus.md_op     = md_op_r;
    assign bus.md_a      = md_a_r;
    assign bus.md_b      = md_b_r;
    assign bus.proto_err = proto_err_r;
    // Combinational so the issue cycle itself can hold back a dependent D op.
    assign bus.stall_d   = rst_n & bus.d_md_use & ((state_r != IDLE) | issue_now_s);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: stimulus pushes expected unit-input
// cycles and stall values; a negedge monitor pops and compares.
module tb_md_issue_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    typedef struct {
        int          cyc;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } md_exp_t;

    typedef struct {
        int   cyc;
        logic st;
    } st_exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   busy_end;
    int   perr_from;
    logic [31:0] last_a;
    logic [31:0] last_b;
    md_exp_t mq[$];
    st_exp_t sq[$];

    md_issue_ctrl_if bus_if ();

    md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
        end
    endtask

    // One pipeline cycle of stimulus; the reference model decides whether the unit is free.
    task automatic step(input logic v, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic duse);
        bit idle;
        bit issue;
        int lat;
        @(posedge clk);
        #1;
        bus_if.e_valid  = v;
        bus_if.e_op     = op;
        bus_if.e_rs     = rs;
        bus_if.e_rt     = rt;
        bus_if.d_md_use = duse;
        idle  = (cyc > busy_end);
        issue = v && (op >= 4'd1) && (op <= 4'd6) && idle;
        sq.push_back(st_exp_t'{cyc, duse && (!idle || issue)});
        if (issue) begin
            if (op <= 4'd2) lat = MULT_LAT;
            else if (op <= 4'd4) lat = DIV_LAT;
            else lat = 1;
            for (int k = 0; k < lat; k++) mq.push_back(md_exp_t'{cyc + 1 + k, op, rs, rt});
            busy_end = cyc + 1 + lat;
        end else if (v && (op != 4'd0) && !idle) begin
`ifdef MD_PROTO_CHECK_EN
            if (perr_from < 0) perr_from = cyc + 1;
`endif
        end
    endtask

    task automatic idle_cycles(input int n, input logic duse);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, $urandom, $urandom, duse);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic async_reset();
        @(posedge clk);
        #3;
        bus_if.e_valid  = 1'b0;
        bus_if.e_op     = 4'd0;
        bus_if.d_md_use = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_md_op", {28'd0, bus_if.md_op}, 32'd0);
        chk("rst_md_a", bus_if.md_a, 32'd0);
        chk("rst_md_b", bus_if.md_b, 32'd0);
        chk("rst_stall_d", {31'd0, bus_if.stall_d}, 32'd0);
        chk("rst_proto_err", {31'd0, bus_if.proto_err}, 32'd0);
        mq.delete();
        sq.delete();
        busy_end  = -1;
        perr_from = -1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents this cycle against the queues.
    always @(negedge clk) begin
        md_exp_t me;
        st_exp_t se;
        if (rst_n) begin
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                se = sq.pop_front();
                chk("stall_d", {31'd0, bus_if.stall_d}, {31'd0, se.st});
            end
            if (bus_if.md_op != 4'd0) begin
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL md_op_unexpected cycle=%0d actual=%0d required=0", cyc, bus_if.md_op);
                end else begin
                    me = mq.pop_front();
                    chk("md_cycle", cyc, me.cyc);
                    chk("md_op", {28'd0, bus_if.md_op}, {28'd0, me.op});
                    chk("md_a", bus_if.md_a, me.a);
                    chk("md_b", bus_if.md_b, me.b);
                    last_a = me.a;
                    last_b = me.b;
                end
            end else begin
                checks++;
                if (mq.size() > 0 && mq[0].cyc <= cyc) begin
                    errors++;
                    $display("FAIL md_op_missing cycle=%0d actual=0 required=%0d", cyc, mq[0].op);
                end
                chk("md_a_hold", bus_if.md_a, last_a);
                chk("md_b_hold", bus_if.md_b, last_b);
            end
            chk("proto_err", {31'd0, bus_if.proto_err},
                {31'd0, (perr_from >= 0 && cyc >= perr_from) ? 1'b1 : 1'b0});
        end else begin
            last_a = 32'd0;
            last_b = 32'd0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        busy_end  = -1;
        perr_from = -1;
        last_a    = 32'd0;
        last_b    = 32'd0;
        rst_n     = 1'b0;
        bus_if.e_valid  = 1'b0;
        bus_if.e_op     = 4'd0;
        bus_if.e_rs     = 32'd0;
        bus_if.e_rt     = 32'd0;
        bus_if.d_md_use = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("por_md_op", {28'd0, bus_if.md_op}, 32'd0);
        chk("por_md_a", bus_if.md_a, 32'd0);
        chk("por_stall_d", {31'd0, bus_if.stall_d}, 32'd0);
        chk("por_proto_err", {31'd0, bus_if.proto_err}, 32'd0);
        bus_if.d_md_use = 1'b0;
        rst_n = 1'b1;

        // mult 7 * -2
        step(1'b1, 4'd1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
        idle_cycles(8, 1'b0);
        // divu with a dependent HI/LO op waiting in D the whole time
        step(1'b1, 4'd4, 32'd100, 32'd7, 1'b1);
        idle_cycles(14, 1'b1);
        // mthi with D stall, mtlo without
        step(1'b1, 4'd5, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        idle_cycles(3, 1'b1);
        step(1'b1, 4'd6, 32'hCAFE_F00D, 32'h0, 1'b0);
        idle_cycles(3, 1'b0);
        // div with operands churning during RUN
        step(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle_cycles(13, 1'b0);
        // reset in the middle of a div, then a fresh mult
        step(1'b1, 4'd3, 32'd55, 32'd5, 1'b0);
        idle_cycles(2, 1'b0);
        async_reset();
        step(1'b1, 4'd2, 32'hFFFF_FFFF, 32'h0000_0003, 1'b1);
        idle_cycles(8, 1'b0);
        // protocol violation mid-RUN; the injected operands must not land
        step(1'b1, 4'd1, 32'h1111_1111, 32'h2222_2222, 1'b0);
        idle_cycles(2, 1'b0);
        step(1'b1, 4'd1, 32'h3333_3333, 32'h4444_4444, 1'b1);
        idle_cycles(6, 1'b0);

        // randomized traffic, including non-MD opcodes and back-to-back attempts
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 8)),
                 $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        idle_cycles(14, 1'b0);

        chk("md_queue_drained", mq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Issue and interlock controller sitting directly upstream of the multiply/divide unit in the E stage. It captures a multiply/divide/move-to-HI/LO operation from the E pipeline register. It holds the opcode and operands stable at the unit's inputs for the unit's whole latency, then retires the opcode. It also drives the D-stage stall that keeps further HI/LO-class instructions out while the unit is occupied.

## Interface
- MULT_LAT, 5, cycles the unit needs for mult/multu (opcode held this many cycles after issue)
- DIV_LAT, 10, cycles the unit needs for div/divu
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- e_valid  in  1  E-stage instruction valid (not a bubble)
- e_op  in  4  E-stage MD opcode: 0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo
- e_rs  in  32  forwarded rs operand
- e_rt  in  32  forwarded rt operand
- d_md_use  in  1  D-stage instruction is any HI/LO-class op (mult/div family, mfhi/mflo, mthi/mtlo)
- md_op  out  4  opcode to unit
- md_a  out  32  operand A to unit
- md_b  out  32  operand B to unit
- stall_d  out  1  freeze F/D, insert bubble into E
- proto_err  out  1  sticky protocol-violation flag

## Operation
- States: IDLE, RUN, RETIRE.
- IDLE:
  - e_valid with e_op in 0001–0100: latch e_op/e_rs/e_rt into the hold registers, load the countdown with MULT_LAT (0001/0010) or DIV_LAT (0011/0100), go to RUN.
  - e_valid with e_op 0101/0110: latch the same way, countdown = 1, go to RUN.
  - Otherwise stay in IDLE; md_op = 0000.
- RUN:
  - md_op/md_a/md_b driven from the hold registers, stable every cycle.
  - Countdown decrements each cycle; at 1 go to RETIRE.
- RETIRE:
  - md_op = 0000 for exactly one cycle, so the unit's start logic does not re-fire. md_a/md_b keep their last values.
  - Then go to IDLE.
- stall_d = d_md_use & (state != IDLE | issue_now), where issue_now is the IDLE-state issue condition above.
- Non-MD instructions never stall.
- Width rules: operands pass through unmodified. The countdown is 4 bits; DIV_LAT ≤ 15.
- Violation: e_valid with e_op ≠ 0000 while state ≠ IDLE.
  - The op is ignored; the hold registers are unchanged.
  - proto_err is set and stays set until reset.
- Reset (any time, including mid-RUN): state IDLE, countdown 0, md_op 0000, md_a 0, md_b 0, stall_d 0, proto_err 0. The in-flight operation is abandoned.

## Timing
- Issue at edge T0 (e_op sampled in the cycle before T0).
- Mult/multu: md_op valid in cycles T0..T0+MULT_LAT−1, RETIRE (md_op 0000) in cycle T0+MULT_LAT, IDLE from T0+MULT_LAT+1.
- Div/divu: the same pattern with DIV_LAT.
- mthi/mtlo: md_op valid for exactly 1 cycle, then 1 RETIRE cycle.
- stall_d:
  - Combinational.
  - Asserted in the issue cycle itself when D also holds an HI/LO-class op.
  - Deasserts in the first IDLE cycle.
  - Minimum gap between consecutive MD issues: latency + 2 cycles.
- All outputs except stall_d are registered.

## Configuration
- MD_PROTO_CHECK_EN defined: violation detection and sticky proto_err are built as described.
- MD_PROTO_CHECK_EN undefined:
  - proto_err is tied to 0 and no detection logic is synthesised.
  - A violating op is still ignored.

## Test plan
- Reset, then mult e_rs=0x00000007 e_rt=0xFFFFFFFE -> md_op=0001, md_a=7, md_b=0xFFFFFFFE for exactly 5 cycles; 1 cycle 0000; IDLE.
- divu e_rs=100 e_rt=7 with d_md_use=1 held throughout -> stall_d=1 from the issue cycle through RETIRE (12 cycles); md_op=0100 for 10 cycles; stall_d=0 on return to IDLE.
- mthi e_rs=0xDEADBEEF -> md_op=0101, md_a=0xDEADBEEF for 1 cycle, then 0000; stall_d pulses only if d_md_use=1.
- div issued; e_rs/e_rt change every cycle during RUN -> md_a/md_b unchanged from the latched values for all 10 cycles.
- rst_n low at cycle 3 of a div -> all outputs 0 immediately (asynchronously); after release, a new mult issues normally.
- Inject e_valid=1, e_op=0001 mid-RUN:
  - With MD_PROTO_CHECK_EN: proto_err=1 (sticky); the hold registers are unchanged.
  - Without MD_PROTO_CHECK_EN: proto_err=0; the hold registers are unchanged.
